// File: rtl/sound_pkg.sv
// Shared sound codes, player state encoding and the note-sequence ROM.
package sound_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned TONE_W    = 4;
    localparam int unsigned MAX_NOTES = 4;
    localparam int unsigned IDX_W     = $clog2(MAX_NOTES);
    localparam int unsigned LEN_W     = $clog2(MAX_NOTES + 1);

    localparam logic [CODE_W-1:0] MONSTER_HIT_SOUND   = 4'b0001;
    localparam logic [CODE_W-1:0] SPACESHIP_HIT_SOUND = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Number of notes in the sequence for a nonzero code.
    function automatic logic [LEN_W-1:0] seq_len(input logic [CODE_W-1:0] code);
        case (code)
            MONSTER_HIT_SOUND:   return LEN_W'(3);
            SPACESHIP_HIT_SOUND: return LEN_W'(4);
            default:             return LEN_W'(1);
        endcase
    endfunction

    // Tone index of note idx within the sequence for a code.
    function automatic logic [TONE_W-1:0] seq_note(input logic [CODE_W-1:0] code,
                                                   input logic [IDX_W-1:0]  idx);
        case (code)
            MONSTER_HIT_SOUND: begin
                case (idx)
                    IDX_W'(0): return TONE_W'(9);
                    IDX_W'(1): return TONE_W'(7);
                    default:   return TONE_W'(5);
                endcase
            end
            SPACESHIP_HIT_SOUND: return TONE_W'(IDX_W'(3) - idx);
            default:             return TONE_W'(code);
        endcase
    endfunction

endpackage

// File: rtl/sound_player.sv
// Turns the level-held sound code into a timed note sequence for the tone generator.
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 3_150_000,
    parameter int unsigned GAP_TICKS  = 630_000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [CODE_W-1:0] sound_signal,
    output logic [TONE_W-1:0] tone_index,
    output logic              sound_enable,
    output logic              busy
);

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  note_idx, idx_nxt;
    logic [CODE_W-1:0] active_code, code_nxt;
    logic [CODE_W-1:0] prev_code;
    logic [TONE_W-1:0] tone_nxt;
    logic              en_nxt;
    logic              busy_nxt;
    logic              trigger;
    logic              last_note;

    // A new nonzero code (edge on the held level) starts or restarts a sequence.
    assign trigger   = (sound_signal != prev_code) && (sound_signal != '0);
    assign last_note = (LEN_W'(note_idx) == (seq_len(active_code) - LEN_W'(1)));

    // State, sequencing registers and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt          <= '0;
            note_idx     <= '0;
            active_code  <= '0;
            prev_code    <= '0;
            tone_index   <= '0;
            sound_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            note_idx     <= idx_nxt;
            active_code  <= code_nxt;
            prev_code    <= sound_signal;
            tone_index   <= tone_nxt;
            sound_enable <= en_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next state and duration counter; a trigger always wins, even on the final gap cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = note_idx;
        code_nxt  = active_code;
        if (trigger) begin
            state_nxt = PLAY;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            code_nxt  = sound_signal;
        end else begin
            case (state)
                IDLE: cnt_nxt = '0;
                PLAY: begin
                    if (cnt == NOTE_LAST) begin
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        if (last_note) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = PLAY;
                            idx_nxt   = note_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output values for the upcoming state; tone holds its last note outside PLAY.
    always_comb begin
        tone_nxt = tone_index;
        en_nxt   = 1'b0;
        busy_nxt = (state_nxt != IDLE);
        if (state_nxt == PLAY) begin
            en_nxt   = 1'b1;
            tone_nxt = seq_note(code_nxt, idx_nxt);
        end
    end

endmodule

// File: tb/tb_sound_player.sv
// Randomized bench for sound_player against a time-based sequence model.
module tb_sound_player;

    localparam int unsigned NOTE_TICKS = 4;
    localparam int unsigned GAP_TICKS  = 2;
    localparam int unsigned PERIOD     = NOTE_TICKS + GAP_TICKS;

    logic       clk;
    logic       resetN;
    logic [3:0] sound_signal;
    logic [3:0] tone_index;
    logic       sound_enable;
    logic       busy;

    int n_checks;
    int n_fail;

    // model state
    logic [3:0] m_prev;
    logic [3:0] m_code;
    int         m_el;
    bit         m_active;
    int         m_tone;

    sound_player #(
        .NOTE_TICKS(NOTE_TICKS),
        .GAP_TICKS (GAP_TICKS),
        .CNT_W     (22)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .sound_signal(sound_signal),
        .tone_index  (tone_index),
        .sound_enable(sound_enable),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_len(input int code);
        if (code == 1)  return 3;
        if (code == 13) return 4;
        return 1;
    endfunction

    function automatic int m_note(input int code, input int k);
        int tbl_m[3] = '{9, 7, 5};
        if (code == 1)  return tbl_m[k];
        if (code == 13) return 3 - k;
        return code;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle model: a sequence is a start time plus a code; outputs follow from elapsed cycles.
    task automatic monitor();
        bit trig;
        int e_tone, e_en, e_busy;
        forever begin
            @(posedge clk);
            if (!resetN) begin
                m_prev   = 4'd0;
                m_active = 1'b0;
                m_tone   = 0;
            end else begin
                trig   = (sound_signal != m_prev) && (sound_signal != 4'd0);
                m_prev = sound_signal;
                if (trig) begin
                    m_active = 1'b1;
                    m_code   = sound_signal;
                    m_el     = 0;
                end else if (m_active) begin
                    m_el++;
                    if (m_el >= m_len(int'(m_code)) * int'(PERIOD)) m_active = 1'b0;
                end
            end
            if (m_active) begin
                e_en   = ((m_el % int'(PERIOD)) < int'(NOTE_TICKS)) ? 1 : 0;
                e_tone = m_note(int'(m_code), m_el / int'(PERIOD));
                m_tone = e_tone;
                e_busy = 1;
            end else begin
                e_en   = 0;
                e_tone = m_tone;
                e_busy = 0;
            end
            #1;
            chk("cyc_tone", int'(tone_index), e_tone);
            chk("cyc_enable", int'(sound_enable), e_en);
            chk("cyc_busy", int'(busy), e_busy);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input int t, input int en, input int b);
        chk({name, "_tone"}, int'(tone_index), t);
        chk({name, "_enable"}, int'(sound_enable), en);
        chk({name, "_busy"}, int'(busy), b);
    endtask

    initial begin
        int r;
        int code;
        n_checks     = 0;
        n_fail       = 0;
        m_prev       = 4'd0;
        m_code       = 4'd0;
        m_el         = 0;
        m_active     = 1'b0;
        m_tone       = 0;
        resetN       = 1'b0;
        sound_signal = 4'd0;
        fork
            monitor();
        join_none

        cyc(3);
        resetN = 1'b1;
        cyc(2);
        expect_out("reset", 0, 0, 0);

        // monster hit: 9,7,5 with 4 on / 2 off
        sound_signal = 4'b0001;
        cyc(1);  expect_out("mon_first", 9, 1, 1);
        cyc(4);  expect_out("mon_gap1", 9, 0, 1);
        cyc(2);  expect_out("mon_note2", 7, 1, 1);
        cyc(6);  expect_out("mon_note3", 5, 1, 1);
        cyc(5);  expect_out("mon_lastgap", 5, 0, 1);
        cyc(1);  expect_out("mon_done", 5, 0, 0);
        sound_signal = 4'b0000;
        cyc(5);

        // spaceship held for 100 cycles plays once
        sound_signal = 4'b1101;
        cyc(1);  expect_out("ship_first", 3, 1, 1);
        cyc(23); expect_out("ship_lastgap", 0, 0, 1);
        cyc(1);  expect_out("ship_done", 0, 0, 0);
        cyc(76); expect_out("ship_held", 0, 0, 0);
        sound_signal = 4'b0000;
        cyc(2);

        // preemption on the third cycle of a monster sequence
        sound_signal = 4'b0001;
        cyc(3);
        sound_signal = 4'b1101;
        cyc(1);  expect_out("preempt", 3, 1, 1);
        cyc(4);  expect_out("preempt_gap", 3, 0, 1);
        cyc(30);
        sound_signal = 4'b0000;
        cyc(2);

        // code drops to zero mid-sequence, playback completes, then retrigger
        sound_signal = 4'b0001;
        cyc(3);
        sound_signal = 4'b0000;
        cyc(15); expect_out("drop_busy", 5, 0, 1);
        cyc(1);  expect_out("drop_done", 5, 0, 0);
        sound_signal = 4'b0001;
        cyc(1);  expect_out("retrig", 9, 1, 1);
        cyc(20);
        sound_signal = 4'b0000;
        cyc(2);

        // unknown code: single note equal to the code
        sound_signal = 4'b0110;
        cyc(1);  expect_out("unk_first", 6, 1, 1);
        cyc(3);  expect_out("unk_last_on", 6, 1, 1);
        cyc(1);  expect_out("unk_gap", 6, 0, 1);
        cyc(2);  expect_out("unk_done", 6, 0, 0);
        sound_signal = 4'b0000;
        cyc(2);

        // async reset during the first note, code held
        sound_signal = 4'b0001;
        cyc(2);
        #2 resetN = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0);
        cyc(2);
        resetN = 1'b1;
        cyc(1);  expect_out("rst_retrig", 9, 1, 1);
        cyc(20);
        sound_signal = 4'b0000;
        cyc(2);

        // randomized code changes with occasional reset pulses
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      code = 0;
            else if (r <= 4) code = 1;
            else if (r <= 6) code = 13;
            else             code = int'($urandom_range(1, 15));
            sound_signal = 4'(code);
            if ($urandom_range(0, 19) == 0) begin
                #3 resetN = 1'b0;
                cyc(int'($urandom_range(1, 2)));
                resetN = 1'b1;
            end
            cyc(int'($urandom_range(1, 25)));
        end
        sound_signal = 4'b0000;
        cyc(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
